cluster_clock_sel_ctrl: RTL

- Parametrised, sequenced clock-select controller; successor to the plain 2-input cluster clock mux.
- Runs entirely in the always-on reference clock domain.
- Accepts switch requests over a valid/ready handshake and drives a one-hot select bus plus a clock-gate enable for the downstream N-input clock mux/gate cell.
- Every switch is sequenced so the mux input changes only while the output clock is gated off: gate off, wait, switch, settle, gate on.

---
 rtl/cluster_clock_sel_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cluster_clock_sel_ctrl.sv
// rtl/cluster_clock_sel_ctrl.sv - sequenced N-input clock-select controller (gate off, switch, settle, gate on)
// Optional switch counter on sw_cnt_o enabled by defining CLUSTER_CLOCK_SEL_CNT_EN.
module cluster_clock_sel_ctrl #(
  parameter int NUM_CLK      = 4,
  parameter int SEL_W        = $clog2(NUM_CLK),
  parameter int RST_SEL      = 0,
  parameter int GATE_OFF_CYC = 2,
  parameter int SETTLE_CYC   = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  input  logic [SEL_W-1:0]   req_sel_i,
  output logic               req_ready_o,
  output logic [NUM_CLK-1:0] clk_sel_oh_o,
  output logic               clk_gate_en_o,
  output logic [SEL_W-1:0]   cur_sel_o,
  output logic               busy_o,
  output logic               err_o,
  output logic [15:0]        sw_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATE_OFF,
    S_SWITCH,
    S_SETTLE
  } state_t;

  localparam logic [NUM_CLK-1:0] ONE_OH = NUM_CLK'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_cnt;
  logic [3:0]         w_cnt_nxt;
  logic [SEL_W-1:0]   r_target;
  logic [SEL_W-1:0]   w_target_nxt;
  logic [SEL_W-1:0]   r_cur_sel;
  logic [NUM_CLK-1:0] r_sel_oh;
  logic               r_gate_en;
  logic               r_err;
  logic               w_err_nxt;
  logic               w_accept;
  logic               w_illegal;
  logic [31:0]        w_req_idx;
  logic               w_sw_done;

  // Widened so the range check stays meaningful when NUM_CLK is a power of two.
  assign w_req_idx = 32'(req_sel_i);
  assign w_illegal = (w_req_idx >= 32'(NUM_CLK));
  assign w_accept  = req_valid_i && (r_state == S_IDLE);
  assign w_sw_done = (r_state == S_SETTLE) && (r_cnt == 4'd0);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_target_nxt = r_target;
    w_err_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_illegal) begin
            w_err_nxt = 1'b1;
          end else if (req_sel_i != r_cur_sel) begin
            w_target_nxt = req_sel_i;
            w_cnt_nxt    = 4'(GATE_OFF_CYC - 1);
            w_state_nxt  = S_GATE_OFF;
          end
        end
      end
      S_GATE_OFF: begin
        if (r_cnt == 4'd0) w_state_nxt = S_SWITCH;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_SWITCH: begin
        w_cnt_nxt   = 4'(SETTLE_CYC - 1);
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_target  <= SEL_W'(RST_SEL);
      r_cur_sel <= SEL_W'(RST_SEL);
      r_sel_oh  <= ONE_OH << RST_SEL;
      r_gate_en <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_target  <= w_target_nxt;
      r_err     <= w_err_nxt;
      // Gate enable is a flop driven from next state so it never glitches.
      r_gate_en <= (w_state_nxt == S_IDLE);
      if (r_state == S_SWITCH) begin
        r_cur_sel <= r_target;
        r_sel_oh  <= ONE_OH << r_target;
      end
    end
  end

`ifdef CLUSTER_CLOCK_SEL_CNT_EN
  logic [15:0] r_sw_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sw_cnt <= 16'h0000;
    end else if (w_sw_done && (r_sw_cnt != 16'hFFFF)) begin
      r_sw_cnt <= r_sw_cnt + 16'h0001;
    end
  end

  assign sw_cnt_o = r_sw_cnt;
`else
  logic w_unused_sw_done;
  assign w_unused_sw_done = w_sw_done;
  assign sw_cnt_o         = 16'h0000;
`endif

  assign req_ready_o   = (r_state == S_IDLE);
  assign busy_o        = (r_state != S_IDLE);
  assign clk_gate_en_o = r_gate_en;
  assign clk_sel_oh_o  = r_sel_oh;
  assign cur_sel_o     = r_cur_sel;
  assign err_o         = r_err;

endmodule
